// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side operands and control, hazard stall/flush,
// forwarding sources from EX/MEM and MEM/WB, and the operands and control
// presented to EX. The slave modport is the stage itself; the master
// modport is the surrounding pipeline that drives ID and consumes EX.
interface id_ex_stage_if #(
  parameter int N = 32
);
  logic         stall;
  logic         flush;
  logic         id_valid;
  logic [N-1:0] id_pc;
  logic [N-1:0] id_rs1_data;
  logic [N-1:0] id_rs2_data;
  logic [N-1:0] id_imm;
  logic [4:0]   id_rs1;
  logic [4:0]   id_rs2;
  logic [4:0]   id_rd;
  logic [2:0]   id_funct3;
  logic         id_funct7b5;
  logic [1:0]   id_alu_op;
  logic         id_alu_src;
  logic         id_reg_write;
  logic         id_mem_read;
  logic         id_mem_write;
  logic         id_mem_to_reg;
  logic         id_branch;
  logic [4:0]   exmem_rd;
  logic         exmem_reg_write;
  logic [N-1:0] exmem_alu_result;
  logic [4:0]   memwb_rd;
  logic         memwb_reg_write;
  logic [N-1:0] memwb_wdata;
  logic         ex_valid;
  logic [3:0]   ex_alu_sel;
  logic [N-1:0] ex_alu_a;
  logic [N-1:0] ex_alu_b;
  logic [N-1:0] ex_store_data;
  logic [N-1:0] ex_pc;
  logic [N-1:0] ex_imm;
  logic [4:0]   ex_rd;
  logic         ex_reg_write;
  logic         ex_mem_read;
  logic         ex_mem_write;
  logic         ex_mem_to_reg;
  logic         ex_branch;

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, id_alu_op,
           id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, exmem_rd, exmem_reg_write,
           exmem_alu_result, memwb_rd, memwb_reg_write, memwb_wdata,
    output ex_valid, ex_alu_sel, ex_alu_a, ex_alu_b, ex_store_data, ex_pc,
           ex_imm, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_branch
  );

  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, id_alu_op,
           id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, exmem_rd, exmem_reg_write,
           exmem_alu_result, memwb_rd, memwb_reg_write, memwb_wdata,
    input  ex_valid, ex_alu_sel, ex_alu_a, ex_alu_b, ex_store_data, ex_pc,
           ex_imm, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_branch
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
// Decodes the 4-bit ALU select in ID, registers operands and control, and
// resolves A/B operands in EX. Optional macro ALU_FWD_EN enables EX/MEM and
// MEM/WB operand forwarding; without it the registered register-file data is
// used as-is and the hazard unit has to stall on dependences.
module id_ex_stage #(
  parameter int N = 32
) (
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);

  logic         valid_q;
  logic [N-1:0] pc_q;
  logic [N-1:0] imm_q;
  logic [N-1:0] rs1_data_q;
  logic [N-1:0] rs2_data_q;
  logic [4:0]   rd_q;
  logic [3:0]   alu_sel_q;
  logic         alu_src_q;
  logic         reg_write_q;
  logic         mem_read_q;
  logic         mem_write_q;
  logic         mem_to_reg_q;
  logic         branch_q;
  logic [3:0]   dec_sel;
  logic [N-1:0] fwd_a;
  logic [N-1:0] fwd_b;

  // Translate ALUOp/funct into the ALU select; 1111 marks an unsupported op
  always_comb begin
    dec_sel = 4'b1111;
    case (bus.id_alu_op)
      2'b00: dec_sel = 4'b0010;
      2'b01: dec_sel = 4'b0110;
      2'b10: begin
        case (bus.id_funct3)
          3'b000:  dec_sel = bus.id_funct7b5 ? 4'b0110 : 4'b0010;
          3'b111:  dec_sel = 4'b0000;
          3'b110:  dec_sel = 4'b0001;
          default: dec_sel = 4'b1111;
        endcase
      end
      default: begin
        case (bus.id_funct3)
          3'b000:  dec_sel = 4'b0010;
          3'b111:  dec_sel = 4'b0000;
          3'b110:  dec_sel = 4'b0001;
          default: dec_sel = 4'b1111;
        endcase
      end
    endcase
  end

  // Stage register: reset and flush insert a bubble, stall holds, else load
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      rd_q         <= '0;
      alu_sel_q    <= 4'b0000;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
    end else if (!bus.stall) begin
      valid_q      <= bus.id_valid;
      pc_q         <= bus.id_pc;
      imm_q        <= bus.id_imm;
      rs1_data_q   <= bus.id_rs1_data;
      rs2_data_q   <= bus.id_rs2_data;
      rd_q         <= bus.id_rd;
      alu_sel_q    <= dec_sel;
      alu_src_q    <= bus.id_alu_src;
      reg_write_q  <= bus.id_valid & bus.id_reg_write;
      mem_read_q   <= bus.id_valid & bus.id_mem_read;
      mem_write_q  <= bus.id_valid & bus.id_mem_write;
      mem_to_reg_q <= bus.id_valid & bus.id_mem_to_reg;
      branch_q     <= bus.id_valid & bus.id_branch;
    end
  end

`ifdef ALU_FWD_EN
  logic [4:0] rs1_q;
  logic [4:0] rs2_q;

  // Source register indices, kept only for the forwarding comparators
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (!bus.stall) begin
      rs1_q <= bus.id_rs1;
      rs2_q <= bus.id_rs2;
    end
  end

  // Forward the youngest in-flight result; x0 is never forwarded
  always_comb begin
    fwd_a = rs1_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs1_q))
      fwd_a = bus.exmem_alu_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs1_q))
      fwd_a = bus.memwb_wdata;
    fwd_b = rs2_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs2_q))
      fwd_b = bus.exmem_alu_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs2_q))
      fwd_b = bus.memwb_wdata;
  end
`else
  // No forwarding network: operands come straight from the register file read
  always_comb begin
    fwd_a = rs1_data_q;
    fwd_b = rs2_data_q;
  end
`endif

  assign bus.ex_valid      = valid_q;
  assign bus.ex_alu_sel    = alu_sel_q;
  assign bus.ex_alu_a      = fwd_a;
  assign bus.ex_alu_b      = alu_src_q ? imm_q : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_mem_to_reg = mem_to_reg_q;
  assign bus.ex_branch     = branch_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: vector table applied through a scoreboard queue,
// plus hand-written reset, stall and flush sequences.
module tb_id_ex_stage;

  localparam int N = 32;
`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7, src;
    logic [4:0]  ctl;
    logic [4:0]  xrd;
    logic        xw;
    logic [31:0] xres;
    logic [4:0]  wrd;
    logic        ww;
    logic [31:0] wd;
    logic [3:0]  e_sel;
    logic [31:0] e_a, e_b, e_st;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [3:0]  sel;
    logic [31:0] a, b, st, pc, imm;
    logic [4:0]  rd;
    logic [4:0]  ctl;
  } exp_t;

  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;
  vec_t vecs[$];
  exp_t sb[$];
  exp_t zero_exp;
  exp_t held;

  id_ex_stage_if #(.N(N)) bus ();

  id_ex_stage #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkv(
    input logic v, input logic [31:0] pc, rs1d, rs2d, imm,
    input logic [4:0] rs1, rs2, rd, input logic [1:0] op, input logic [2:0] f3,
    input logic f7, src, input logic [4:0] ctl,
    input logic [4:0] xrd, input logic xw, input logic [31:0] xres,
    input logic [4:0] wrd, input logic ww, input logic [31:0] wd,
    input logic [3:0] e_sel, input logic [31:0] e_a, e_b, e_st);
    vec_t t;
    t.valid = v; t.pc = pc; t.rs1d = rs1d; t.rs2d = rs2d; t.imm = imm;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.op = op; t.f3 = f3; t.f7 = f7;
    t.src = src; t.ctl = ctl; t.xrd = xrd; t.xw = xw; t.xres = xres;
    t.wrd = wrd; t.ww = ww; t.wd = wd; t.e_sel = e_sel; t.e_a = e_a;
    t.e_b = e_b; t.e_st = e_st;
    return t;
  endfunction

  function automatic exp_t exp_of(input vec_t t);
    exp_t e;
    e.valid = t.valid; e.sel = t.e_sel; e.a = t.e_a; e.b = t.e_b; e.st = t.e_st;
    e.pc = t.pc; e.imm = t.imm; e.rd = t.rd;
    e.ctl = t.valid ? t.ctl : 5'b00000;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t, input bit push);
    bus.id_valid = t.valid; bus.id_pc = t.pc; bus.id_rs1_data = t.rs1d;
    bus.id_rs2_data = t.rs2d; bus.id_imm = t.imm; bus.id_rs1 = t.rs1;
    bus.id_rs2 = t.rs2; bus.id_rd = t.rd; bus.id_alu_op = t.op;
    bus.id_funct3 = t.f3; bus.id_funct7b5 = t.f7; bus.id_alu_src = t.src;
    {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
     bus.id_mem_to_reg, bus.id_branch} = t.ctl;
    bus.exmem_rd = t.xrd; bus.exmem_reg_write = t.xw; bus.exmem_alu_result = t.xres;
    bus.memwb_rd = t.wrd; bus.memwb_reg_write = t.ww; bus.memwb_wdata = t.wd;
    if (push) sb.push_back(exp_of(t));
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      assert_count++;
      fail_count++;
      $display("[TB] FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".valid"}, {31'd0, bus.ex_valid}, {31'd0, e.valid});
      check({tag, ".sel"},   {28'd0, bus.ex_alu_sel}, {28'd0, e.sel});
      check({tag, ".a"},     bus.ex_alu_a, e.a);
      check({tag, ".b"},     bus.ex_alu_b, e.b);
      check({tag, ".store"}, bus.ex_store_data, e.st);
      check({tag, ".pc"},    bus.ex_pc, e.pc);
      check({tag, ".imm"},   bus.ex_imm, e.imm);
      check({tag, ".rd"},    {27'd0, bus.ex_rd}, {27'd0, e.rd});
      check({tag, ".ctl"},   {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                              bus.ex_mem_to_reg, bus.ex_branch}, {27'd0, e.ctl});
    end
  endtask

  initial begin
    vec_t other;
    assert_count = 0;
    fail_count   = 0;
    zero_exp     = '{valid: 1'b0, sel: 4'd0, a: 32'd0, b: 32'd0, st: 32'd0,
                     pc: 32'd0, imm: 32'd0, rd: 5'd0, ctl: 5'd0};
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // ctl = {reg_write, mem_read, mem_write, mem_to_reg, branch}
    vecs.push_back(mkv(1, 32'h100, 10, 3, 0, 1, 2, 3, 2'b10, 3'b000, 0, 0, 5'b10000, 0,0,0, 0,0,0, 4'b0010, 10, 3, 3));
    vecs.push_back(mkv(1, 32'h104, 10, 3, 0, 1, 2, 4, 2'b10, 3'b000, 1, 0, 5'b10000, 0,0,0, 0,0,0, 4'b0110, 10, 3, 3));
    vecs.push_back(mkv(1, 32'h108, 10, 3, 0, 1, 2, 5, 2'b10, 3'b111, 0, 0, 5'b10000, 0,0,0, 0,0,0, 4'b0000, 10, 3, 3));
    vecs.push_back(mkv(1, 32'h10C, 10, 3, 0, 1, 2, 6, 2'b10, 3'b110, 0, 0, 5'b10000, 0,0,0, 0,0,0, 4'b0001, 10, 3, 3));
    vecs.push_back(mkv(1, 32'h110, 10, 3, 0, 1, 2, 7, 2'b10, 3'b001, 0, 0, 5'b10000, 0,0,0, 0,0,0, 4'b1111, 10, 3, 3));
    vecs.push_back(mkv(1, 32'h114, 10, 3, 0, 1, 2, 8, 2'b10, 3'b010, 1, 0, 5'b10000, 0,0,0, 0,0,0, 4'b1111, 10, 3, 3));
    vecs.push_back(mkv(1, 32'h118, 10, 3, 32'h0F, 1, 2, 9, 2'b11, 3'b110, 0, 1, 5'b10000, 0,0,0, 0,0,0, 4'b0001, 10, 32'h0F, 3));
    vecs.push_back(mkv(1, 32'h11C, 10, 3, 32'hFFFFFFFC, 1, 2, 9, 2'b11, 3'b000, 1, 1, 5'b10000, 0,0,0, 0,0,0, 4'b0010, 10, 32'hFFFFFFFC, 3));
    vecs.push_back(mkv(1, 32'h120, 10, 3, 32'h55, 1, 2, 9, 2'b11, 3'b111, 0, 1, 5'b10000, 0,0,0, 0,0,0, 4'b0000, 10, 32'h55, 3));
    vecs.push_back(mkv(1, 32'h124, 10, 3, 32'h2, 1, 2, 9, 2'b11, 3'b101, 0, 1, 5'b10000, 0,0,0, 0,0,0, 4'b1111, 10, 32'h2, 3));
    vecs.push_back(mkv(1, 32'h128, 10, 3, 32'h8, 1, 2, 11, 2'b00, 3'b010, 0, 1, 5'b11010, 0,0,0, 0,0,0, 4'b0010, 10, 32'h8, 3));
    vecs.push_back(mkv(1, 32'h12C, 10, 3, 32'hC, 1, 2, 0, 2'b00, 3'b010, 0, 1, 5'b00100, 0,0,0, 0,0,0, 4'b0010, 10, 32'hC, 3));
    vecs.push_back(mkv(1, 32'h130, 10, 3, 32'h40, 1, 2, 0, 2'b01, 3'b000, 0, 0, 5'b00001, 0,0,0, 0,0,0, 4'b0110, 10, 3, 3));
    vecs.push_back(mkv(0, 32'h134, 10, 3, 0, 1, 2, 12, 2'b10, 3'b111, 0, 0, 5'b10100, 0,0,0, 0,0,0, 4'b0000, 10, 3, 3));
    vecs.push_back(mkv(1, 32'h200, 32'h11, 32'h22, 0, 5, 9, 1, 2'b00, 3'b000, 0, 0, 5'b10000,
                       5, 1, 32'hAA, 5, 1, 32'hBB, 4'b0010, FWD ? 32'hAA : 32'h11, 32'h22, 32'h22));
    vecs.push_back(mkv(1, 32'h204, 32'h11, 32'h22, 0, 5, 9, 1, 2'b00, 3'b000, 0, 0, 5'b10000,
                       0, 1, 32'hAA, 5, 1, 32'hBB, 4'b0010, FWD ? 32'hBB : 32'h11, 32'h22, 32'h22));
    vecs.push_back(mkv(1, 32'h208, 32'h11, 32'h22, 0, 0, 9, 1, 2'b00, 3'b000, 0, 0, 5'b10000,
                       0, 1, 32'hAA, 0, 1, 32'hBB, 4'b0010, 32'h11, 32'h22, 32'h22));
    vecs.push_back(mkv(1, 32'h20C, 32'h11, 32'h22, 0, 5, 9, 1, 2'b00, 3'b000, 0, 0, 5'b10000,
                       5, 0, 32'hAA, 5, 1, 32'hBB, 4'b0010, FWD ? 32'hBB : 32'h11, 32'h22, 32'h22));
    vecs.push_back(mkv(1, 32'h210, 32'h11, 32'h22, 0, 5, 6, 1, 2'b00, 3'b000, 0, 0, 5'b10000,
                       5, 1, 32'hAA, 6, 1, 32'hBB, 4'b0010, FWD ? 32'hAA : 32'h11,
                       FWD ? 32'hBB : 32'h22, FWD ? 32'hBB : 32'h22));
    vecs.push_back(mkv(1, 32'h214, 32'h11, 32'h22, 32'h40, 1, 6, 1, 2'b00, 3'b000, 0, 1, 5'b10000,
                       6, 1, 32'hAA, 0, 0, 0, 4'b0010, 32'h11, 32'h40, FWD ? 32'hAA : 32'h22));

    // Reset with a valid instruction presented must still yield a bubble
    applyStimulus(vecs[0], 1'b0);
    rst = 1'b1;
    sb.push_back(zero_exp);
    tick();
    checkOutput("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], 1'b1);
      tick();
      checkOutput($sformatf("vec%0d", i));
    end

    // Load an add with rd=7, then stall two cycles with different ID inputs
    applyStimulus(mkv(1, 32'h300, 32'h1234, 32'h77, 32'h9, 2, 3, 7, 2'b00, 3'b000, 0, 0, 5'b10000,
                      0,0,0, 0,0,0, 4'b0010, 32'h1234, 32'h77, 32'h77), 1'b1);
    held = sb[sb.size()-1];
    tick();
    checkOutput("stall_load");
    other = mkv(1, 32'h400, 32'h9999, 32'h8888, 32'h1, 4, 8, 9, 2'b01, 3'b111, 1, 1, 5'b01101,
                0,0,0, 0,0,0, 4'b0110, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      bus.stall = 1'b1;
      applyStimulus(other, 1'b0);
      sb.push_back(held);
      tick();
      checkOutput($sformatf("stall%0d", i));
    end

    // Flush wins over a concurrent stall
    bus.flush = 1'b1;
    sb.push_back(zero_exp);
    tick();
    checkOutput("stall_flush");
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Normal loading resumes after the bubble
    applyStimulus(vecs[6], 1'b1);
    tick();
    checkOutput("resume");

    // Flush alone also bubbles
    bus.flush = 1'b1;
    sb.push_back(zero_exp);
    tick();
    checkOutput("flush");
    bus.flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that feeds the N-bit ALU in the EX stage.
- Latches decoded operands and control from ID and generates the 4-bit ALU select code from ALUOp/funct fields.
- Applies EX/MEM and MEM/WB operand forwarding, then presents the final A/B operands, select code and downstream control to EX.
- Supports stall (hold) and flush (bubble) from the hazard/branch logic.

Parameters:
- N, 32, datapath width of PC, register data, immediate and forwarded results.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  replace stage contents with a bubble
- id_valid  in  1  ID holds a real instruction
- id_pc  in  N  instruction PC
- id_rs1_data, id_rs2_data  in  N  register-file read data
- id_imm  in  N  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct3  in  3  instruction funct3
- id_funct7b5  in  1  instruction bit 30
- id_alu_op  in  2  00 add, 01 sub, 10 R-type, 11 I-type arithmetic
- id_alu_src  in  1  1 = B operand is immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control
- exmem_rd  in  5; exmem_reg_write  in  1; exmem_alu_result  in  N  EX/MEM forwarding source
- memwb_rd  in  5; memwb_reg_write  in  1; memwb_wdata  in  N  MEM/WB forwarding source
- ex_valid  out  1  EX holds a real instruction
- ex_alu_sel  out  4  ALU select code
- ex_alu_a, ex_alu_b  out  N  final ALU operands
- ex_store_data  out  N  forwarded rs2 value for stores
- ex_pc, ex_imm  out  N  registered PC and immediate
- ex_rd  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Update priority at each rising edge: rst > flush > stall > load.
- rst or flush: all registers clear to 0 (ex_valid=0, all control 0, data 0, ex_alu_sel=4'b0000). flush during stall still bubbles.
- stall (no rst/flush): every register holds its value.
- load: capture all id_* fields; ex_valid=id_valid.
  - If id_valid=0, the control bits are captured as 0.
- Latency: exactly 1 cycle from ID inputs to registered outputs.
- ALU select (decoded in ID, registered):
  - alu_op 00 -> 0010 (add); alu_op 01 -> 0110 (sub).
  - alu_op 10: funct3 000 -> 0110 if funct7b5=1, else 0010; 111 -> 0000; 110 -> 0001; others -> 1111.
  - alu_op 11: funct3 000 -> 0010 (funct7b5 ignored); 111 -> 0000; 110 -> 0001; others -> 1111.
  - 1111 is an unsupported op; the ALU outputs zero for it.
- Forwarding (combinational, from the registered rs1/rs2 indices and data):
  - fwdA = exmem_alu_result if exmem_reg_write && exmem_rd!=0 && exmem_rd==rs1;
  - else memwb_wdata if memwb_reg_write && memwb_rd!=0 && memwb_rd==rs1;
  - else the registered rs1_data.
  - fwdB: same rule on rs2. EX/MEM always wins over MEM/WB.
  - Register x0 is never forwarded.
- Operand outputs:
  - ex_alu_a = fwdA.
  - ex_alu_b = ex_imm if alu_src, else fwdB.
  - ex_store_data = fwdB regardless of alu_src.
- Forwarding is evaluated even when ex_valid=0; downstream ignores the operands because all control is 0.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: forwarding as specified above.
- Undefined:
  - fwdA and fwdB equal the registered register data.
  - The exmem_*/memwb_* inputs are unused.
  - The hazard unit must stall instead of relying on forwarding.

Test Plan:
- Reset: rst=1 for 1 cycle with id_valid=1 -> next cycle ex_valid=0, all control 0, ex_alu_sel=0000, data 0.
- R-type sub: id_alu_op=10, funct3=000, funct7b5=1, rs1_data=10, rs2_data=3 -> after 1 cycle ex_alu_sel=0110, ex_alu_a=10, ex_alu_b=3.
- I-type: id_alu_op=11, funct3=110, imm=0x0F, alu_src=1 -> ex_alu_sel=0001, ex_alu_b=0x0F.
- Forward priority (ALU_FWD_EN): rs1=5, exmem_rd=5/result=0xAA, memwb_rd=5/wdata=0xBB, both write=1 -> ex_alu_a=0xAA.
  - exmem_rd=0 -> ex_alu_a=0xBB.
  - rs1=0 -> ex_alu_a=registered rs1_data.
- Stall then flush: load add with rd=7; stall=1 for 2 cycles with changed ID inputs -> outputs unchanged; stall=1 and flush=1 -> next cycle ex_valid=0, ex_reg_write=0.
- Bubble via id_valid: id_valid=0, id_reg_write=1, id_mem_write=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
